expr_batch_sequencer: RTL and testbench
=======================================

# expr_batch_sequencer

Batch scheduler in front of the calculator. It walks a table of expression start indices and, for each entry, points the calculator at that expression, pulses its start, and waits for done or a timeout. It then captures the result and moves to the next entry. It sits between the board-level control (run/abort buttons) and the calculator's `start`/`done` handshake, replacing manual start presses.

## Interface
Parameters:
- CNT_W, 4: width of expression count and table address
- ADDR_W, 8: width of expression start index
- DATA_W, 8: width of calculator result
- TIMEOUT, 1024: max cycles allowed per expression (≥4)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; sampled only in IDLE; high starts a batch
- abort  in  1  level; any state except IDLE returns to IDLE next cycle
- n_expr  in  CNT_W  number of table entries in the batch, latched when run is accepted
- tbl_addr  out  CNT_W  address into synchronous expression table
- tbl_data  in  ADDR_W  start index, valid one cycle after tbl_addr
- calc_base  out  ADDR_W  start index presented to calculator, stable from LAUNCH until the next LAUNCH
- calc_start  out  1  one-cycle start pulse to calculator
- calc_done  in  1  calculator done level
- calc_result  in  DATA_W  calculator result, valid while calc_done is high
- res_valid  out  1  one-cycle pulse; res_* valid
- res_data  out  DATA_W  captured result (0 on timeout)
- res_idx  out  CNT_W  table index of the result
- res_timeout  out  1  result came from a timeout
- err_cnt  out  CNT_W  saturating count of timeouts in the current batch
- busy  out  1  high in every state except IDLE
- batch_done  out  1  one-cycle pulse at batch end (not on abort)

## Operation
- States: IDLE, FETCH, WAIT_ROM, LAUNCH, WAIT_DONE, NEXT, FINISH.
- IDLE:
  - With run=1: latch n_expr, clear idx and err_cnt.
  - Go to FINISH if n_expr==0, else FETCH.
- FETCH: drive tbl_addr=idx, then WAIT_ROM.
- WAIT_ROM: capture tbl_data into calc_base, then LAUNCH.
- LAUNCH: calc_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - Completion is a rising edge of calc_done (calc_done=1 while registered previous calc_done=0).
  - A done level left over from the previous expression is ignored.
  - On completion: capture calc_result into res_data, res_timeout=0, then NEXT.
  - Otherwise the counter increments. When it reaches TIMEOUT-1: res_data=0, res_timeout=1, err_cnt+1 (saturates at all-ones), then NEXT.
  - If completion and timeout occur in the same cycle, completion wins.
- NEXT:
  - res_valid=1 with res_idx=idx.
  - If idx==n_expr-1, go to FINISH; else idx+1, then FETCH.
- FINISH: batch_done=1, then IDLE.
- Abort:
  - Takes priority over every other transition.
  - Next state is IDLE; no res_valid or batch_done is emitted for the interrupted entry.
  - res_data, res_idx and err_cnt keep their values.
- The n_expr latched at run is used for the whole batch; later changes on the input are ignored.
- Reset values of all outputs: 0, except busy=0 in IDLE. The registered previous calc_done also resets to 0.

## Timing
- Run accepted at edge T:
  - FETCH during T+1, WAIT_ROM during T+2.
  - LAUNCH during T+3: calc_start=1 and calc_base valid.
- Rising edge of calc_done seen in cycle D: res_valid in cycle D+1.
- Next calc_start is at D+4 (NEXT, FETCH, WAIT_ROM, LAUNCH).
- Timeout: res_valid exactly TIMEOUT+1 cycles after calc_start.
- n_expr=0: busy during T+1 only, with batch_done=1 in that cycle; no calc_start.
- Full-table batch (n_expr=2^CNT_W-1): idx wraps never. The comparison uses the latched n_expr, so no extra entry is issued.
- Asynchronous reset mid-batch: immediately IDLE, all outputs 0. calc_start must not glitch high.

## Test plan
- Reset then run=1, n_expr=3, table {0x00,0x10,0x20}, calculator done 5 cycles after each start with results 7, 9, 11:
  - three calc_start pulses with calc_base 0x00/0x10/0x20;
  - res_valid ×3 with (idx,data)=(0,7),(1,9),(2,11);
  - batch_done once, err_cnt=0.
- n_expr=0 → batch_done one cycle after run; calc_start never asserted; busy high for exactly one cycle.
- TIMEOUT=16, calculator never raises done on entry 1 of 2:
  - entry 1 gives res_valid with res_timeout=1, data=0, exactly 17 cycles after its start;
  - err_cnt=1, and entry 2 still runs.
- calc_done held high from the previous expression across LAUNCH, falling 2 cycles later and rising 6 cycles after that → exactly one result, taken on the rising edge.
- abort asserted during WAIT_DONE of entry 1 of 3 → IDLE next cycle; no res_valid for entry 1, no batch_done. A new run restarts at idx 0.
- rst pulsed low mid-WAIT_DONE → all outputs 0 while low. After release, run works normally.

Source files
------------

// File: rtl/expr_batch_sequencer.sv
// expr_batch_sequencer
// Walks a table of expression start indices and runs the calculator once per
// entry. Each result, or each timeout, is reported on res_*.
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   run_i, abort_i, n_expr_i   board-level batch control
//   tbl_addr_o / tbl_data_i    synchronous expression table (1-cycle read latency)
//   calc_base_o, calc_start_o  calculator launch
//   calc_done_i, calc_result_i calculator completion
//   res_valid_o, res_data_o, res_idx_o, res_timeout_o   per-entry result
//   err_cnt_o, busy_o, batch_done_o                     batch status
//
// state     | meaning
// IDLE      | waiting for run
// FETCH     | table address presented
// WAIT_ROM  | table data captured into calc_base
// LAUNCH    | calc_start pulse, timeout timer loaded
// WAIT_DONE | waiting for calc_done rising edge or timer terminal count
// NEXT      | result reported, advance index
// FINISH    | batch_done pulse
module expr_batch_sequencer #(
    parameter int CNT_W   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  n_expr_i,
    output logic [CNT_W-1:0]  tbl_addr_o,
    input  logic [ADDR_W-1:0] tbl_data_i,
    output logic [ADDR_W-1:0] calc_base_o,
    output logic              calc_start_o,
    input  logic              calc_done_i,
    input  logic [DATA_W-1:0] calc_result_i,
    output logic              res_valid_o,
    output logic [DATA_W-1:0] res_data_o,
    output logic [CNT_W-1:0]  res_idx_o,
    output logic              res_timeout_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic              busy_o,
    output logic              batch_done_o
);

    localparam int TMR_W = $clog2(TIMEOUT);
    // Down-counter loaded in LAUNCH; terminal count 0 falls on the TIMEOUT-th
    // WAIT_DONE cycle, so res_valid lands TIMEOUT+1 cycles after calc_start.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_ROM  = 3'd2;
    localparam logic [2:0] S_LAUNCH    = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_NEXT      = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  n_lat_q, n_lat_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  ridx_q, ridx_d;
    logic              rto_q, rto_d;
    logic              done_prev_q;
    logic              calc_start_q, res_valid_q, batch_done_q, busy_q;
    logic              done_rise;

    // A done level carried over from the previous expression is not a completion.
    assign done_rise = calc_done_i & ~done_prev_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_lat_d = n_lat_q;
        err_d   = err_q;
        base_d  = base_q;
        tmr_d   = tmr_q;
        rdata_d = rdata_q;
        ridx_d  = ridx_q;
        rto_d   = rto_q;
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        n_lat_d = n_expr_i;
                        idx_d   = '0;
                        err_d   = '0;
                        state_d = (n_expr_i == '0) ? S_FINISH : S_FETCH;
                    end
                end
                S_FETCH:    state_d = S_WAIT_ROM;
                S_WAIT_ROM: begin
                    base_d  = tbl_data_i;
                    state_d = S_LAUNCH;
                end
                S_LAUNCH: begin
                    tmr_d   = TMR_LOAD;
                    state_d = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // Completion is checked first so it wins over a coincident timeout.
                    if (done_rise) begin
                        rdata_d = calc_result_i;
                        rto_d   = 1'b0;
                        ridx_d  = idx_q;
                        state_d = S_NEXT;
                    end else if (tmr_q == '0) begin
                        rdata_d = '0;
                        rto_d   = 1'b1;
                        ridx_d  = idx_q;
                        err_d   = (err_q == '1) ? err_q : err_q + CNT_W'(1);
                        state_d = S_NEXT;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                S_NEXT: begin
                    if (idx_q == n_lat_q - CNT_W'(1)) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = S_FETCH;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with the
    // state they belong to and come straight from flops (no decode glitches).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            n_lat_q      <= '0;
            err_q        <= '0;
            base_q       <= '0;
            tmr_q        <= '0;
            rdata_q      <= '0;
            ridx_q       <= '0;
            rto_q        <= 1'b0;
            done_prev_q  <= 1'b0;
            calc_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            batch_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_lat_q      <= n_lat_d;
            err_q        <= err_d;
            base_q       <= base_d;
            tmr_q        <= tmr_d;
            rdata_q      <= rdata_d;
            ridx_q       <= ridx_d;
            rto_q        <= rto_d;
            done_prev_q  <= calc_done_i;
            calc_start_q <= (state_d == S_LAUNCH);
            res_valid_q  <= (state_d == S_NEXT);
            batch_done_q <= (state_d == S_FINISH);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign tbl_addr_o    = idx_q;
    assign calc_base_o   = base_q;
    assign calc_start_o  = calc_start_q;
    assign res_valid_o   = res_valid_q;
    assign res_data_o    = rdata_q;
    assign res_idx_o     = ridx_q;
    assign res_timeout_o = rto_q;
    assign err_cnt_o     = err_q;
    assign busy_o        = busy_q;
    assign batch_done_o  = batch_done_q;

endmodule

// File: tb/tb_expr_batch_sequencer.sv
// Directed bench for expr_batch_sequencer: synchronous table model, calculator
// responses driven step by step, results checked through an expected-result queue.
module tb_expr_batch_sequencer;

    localparam int CNT_W   = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              run = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  n_expr = '0;
    logic [CNT_W-1:0]  tbl_addr;
    logic [ADDR_W-1:0] tbl_data;
    logic [ADDR_W-1:0] calc_base;
    logic              calc_start;
    logic              calc_done = 1'b0;
    logic [DATA_W-1:0] calc_result = '0;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [CNT_W-1:0]  res_idx;
    logic              res_timeout;
    logic [CNT_W-1:0]  err_cnt;
    logic              busy;
    logic              batch_done;

    expr_batch_sequencer #(
        .CNT_W(CNT_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run), .abort_i(abort),
        .n_expr_i(n_expr), .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
        .calc_base_o(calc_base), .calc_start_o(calc_start),
        .calc_done_i(calc_done), .calc_result_i(calc_result),
        .res_valid_o(res_valid), .res_data_o(res_data), .res_idx_o(res_idx),
        .res_timeout_o(res_timeout), .err_cnt_o(err_cnt), .busy_o(busy),
        .batch_done_o(batch_done)
    );

    always #5 clk = ~clk;

    logic [ADDR_W-1:0] rom [16];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] outs;
    assign outs = {tbl_addr, calc_base, calc_start, res_valid, res_data, res_idx,
                   res_timeout, err_cnt, busy, batch_done};

    typedef struct {
        logic [CNT_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              to;
        int                cyc;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    res_t mon_r;
    int n_start = 0, n_bdone = 0, n_busy = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (calc_start) n_start++;
            if (batch_done) n_bdone++;
            if (busy) n_busy++;
            if (res_valid) begin
                mon_r.idx  = res_idx;
                mon_r.data = res_data;
                mon_r.to   = res_timeout;
                mon_r.cyc  = cyc;
                obs_q.push_back(mon_r);
            end
        end
    end

    int total = 0, bad = 0;
    int run_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [CNT_W-1:0] i, input logic [DATA_W-1:0] d,
                            input logic t, input int c);
        res_t e;
        e.idx = i; e.data = d; e.to = t; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        res_t o, e;
        chk({tag, "_res_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_res_idx"}, 64'(o.idx), 64'(e.idx));
            chk({tag, "_res_data"}, 64'(o.data), 64'(e.data));
            chk({tag, "_res_timeout"}, 64'(o.to), 64'(e.to));
            chk({tag, "_res_cycle"}, 64'(o.cyc), 64'(e.cyc));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_batch(input logic [CNT_W-1:0] n);
        @(negedge clk);
        n_expr  = n;
        run     = 1'b1;
        run_cyc = cyc;
        @(negedge clk);
        run    = 1'b0;
        n_expr = ~n;  // batch must keep using the latched count
    endtask

    task automatic wait_start(input logic [ADDR_W-1:0] eb, input string tag, output int s);
        bit seen = 1'b0;
        s = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (calc_start === 1'b1) seen = 1'b1;
        end
        chk({tag, "_start_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            s = cyc;
            chk({tag, "_base"}, 64'(calc_base), 64'(eb));
        end
    endtask

    // Raise done after dly cycles for one cycle; result expected the following cycle.
    task automatic pulse_done(input logic [CNT_W-1:0] idx, input logic [DATA_W-1:0] val,
                              input int dly);
        repeat (dly) @(negedge clk);
        calc_result = val;
        calc_done   = 1'b1;
        push_exp(idx, val, 1'b0, cyc + 1);
        @(negedge clk);
        calc_done = 1'b0;
    endtask

    task automatic wait_bdone(input string tag, input int b0);
        for (int i = 0; i < 60 && n_bdone == b0; i++) @(negedge clk);
        @(negedge clk);
        chk({tag, "_batch_done_count"}, 64'(n_bdone - b0), 64'd1);
    endtask

    initial begin
        int s0, s1, b0, st0, nb0;

        // reset
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'(outs), 64'd0);
        rst_n = 1'b1;

        // basic three-entry batch
        rom[0] = 8'h00; rom[1] = 8'h10; rom[2] = 8'h20;
        b0 = n_bdone; st0 = n_start;
        run_batch(4'd3);
        wait_start(8'h00, "t1e0", s0);
        chk("t1_launch_latency", 64'(s0 - run_cyc), 64'd3);
        pulse_done(4'd0, 8'd7, 5);
        wait_start(8'h10, "t1e1", s1);
        chk("t1_start_gap", 64'(s1 - s0), 64'd9);
        pulse_done(4'd1, 8'd9, 5);
        wait_start(8'h20, "t1e2", s1);
        pulse_done(4'd2, 8'd11, 5);
        wait_bdone("t1", b0);
        chk("t1_starts", 64'(n_start - st0), 64'd3);
        chk("t1_err_cnt", 64'(err_cnt), 64'd0);
        chk("t1_busy_after", 64'(busy), 64'd0);
        drain("t1");

        // empty batch
        b0 = n_bdone; st0 = n_start; nb0 = n_busy;
        run_batch(4'd0);
        chk("t2_batch_done_now", 64'(batch_done), 64'd1);
        chk("t2_busy_now", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);
        chk("t2_batch_done_count", 64'(n_bdone - b0), 64'd1);
        chk("t2_busy_cycles", 64'(n_busy - nb0), 64'd1);
        chk("t2_starts", 64'(n_start - st0), 64'd0);
        drain("t2");

        // timeout on first of two entries
        rom[0] = 8'h30; rom[1] = 8'h40;
        b0 = n_bdone;
        run_batch(4'd2);
        wait_start(8'h30, "t3e0", s0);
        push_exp(4'd0, 8'd0, 1'b1, s0 + TIMEOUT + 1);
        wait_start(8'h40, "t3e1", s1);
        chk("t3_err_cnt_mid", 64'(err_cnt), 64'd1);
        pulse_done(4'd1, 8'h55, 5);
        wait_bdone("t3", b0);
        chk("t3_err_cnt_end", 64'(err_cnt), 64'd1);
        drain("t3");

        // done level left over across LAUNCH
        rom[0] = 8'h44;
        b0 = n_bdone;
        calc_result = 8'hEE;
        calc_done   = 1'b1;
        run_batch(4'd1);
        wait_start(8'h44, "t4", s0);
        repeat (2) @(negedge clk);
        calc_done = 1'b0;
        pulse_done(4'd0, 8'h77, 6);
        wait_bdone("t4", b0);
        drain("t4");

        // abort during WAIT_DONE, then restart
        rom[0] = 8'h5A; rom[1] = 8'h6B; rom[2] = 8'h7C;
        b0 = n_bdone;
        run_batch(4'd3);
        wait_start(8'h5A, "t5e0", s0);
        pulse_done(4'd0, 8'h21, 5);
        wait_start(8'h6B, "t5e1", s1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        chk("t5_busy_after_abort", 64'(busy), 64'd0);
        abort = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_no_batch_done", 64'(n_bdone - b0), 64'd0);
        chk("t5_res_idx_kept", 64'(res_idx), 64'd0);
        chk("t5_res_data_kept", 64'(res_data), 64'h21);
        drain("t5");
        b0 = n_bdone;
        run_batch(4'd1);
        wait_start(8'h5A, "t5r", s0);
        pulse_done(4'd0, 8'h33, 5);
        wait_bdone("t5r", b0);
        drain("t5r");

        // full-table batch
        for (int k = 0; k < 15; k++) rom[k] = 8'(k * 5 + 1);
        b0 = n_bdone; st0 = n_start;
        run_batch(4'd15);
        for (int k = 0; k < 15; k++) begin
            wait_start(rom[k], "t6", s0);
            pulse_done(4'(k), 8'(k + 8'h80), 1);
        end
        wait_bdone("t6", b0);
        chk("t6_starts", 64'(n_start - st0), 64'd15);
        drain("t6");

        // asynchronous reset mid-batch
        rom[0] = 8'h12; rom[1] = 8'h34;
        run_batch(4'd2);
        wait_start(8'h12, "t7", s0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7_reset_outs_now", 64'(outs), 64'd0);
        repeat (3) @(negedge clk);
        chk("t7_reset_outs_held", 64'(outs), 64'd0);
        rst_n = 1'b1;
        drain("t7");
        b0 = n_bdone;
        run_batch(4'd1);
        wait_start(8'h12, "t7r", s0);
        pulse_done(4'd0, 8'h66, 5);
        wait_bdone("t7r", b0);
        drain("t7r");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
